// File: rtl/mel_band_accum.sv
`default_nettype none
// ============================================================================
//  Module   : mel_band_accum
//  Purpose  : Per-band multiply-accumulate for the log-mel pipeline. Each
//             incoming power-spectrum bin is multiplied by its filter weight,
//             and the products of consecutive samples that share a mel band
//             number are summed. When a band closes (band change or
//             frame_end), the sum is shifted right, saturated to O_BW bits
//             and emitted with a one-cycle do_en pulse. There is no
//             backpressure, so one sample can be accepted on every cycle.
//  Ports    : clk, rst            - clock / asynchronous active-high reset
//             di_en               - input sample valid
//             data_i              - signed bin value (I_BW)
//             weight_i            - unsigned weight, 1.0 = 2^SHIFT (W_BW)
//             in_group_idx        - FFT bin index of the sample
//             in_group_num        - mel band number of the sample
//             frame_end           - last sample of the frame (qualified by di_en)
//             do_en               - one-cycle band output valid
//             data_o              - scaled, saturated band energy (O_BW)
//             out_group_num       - band number of data_o
//             out_first_idx       - bin index of the band's first sample
//             out_bin_cnt         - number of samples summed into the band
//             err_order           - sticky: band number decreased within a frame
//  Revision : 1.0  initial release
// ============================================================================
module mel_band_accum #(
    parameter int I_BW   = 14,
    parameter int W_BW   = 12,
    parameter int ACC_BW = 40,
    parameter int SHIFT  = 11,
    parameter int O_BW   = 24
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   di_en,
    input  logic signed [I_BW-1:0] data_i,
    input  logic        [W_BW-1:0] weight_i,
    input  logic        [9:0]      in_group_idx,
    input  logic        [6:0]      in_group_num,
    input  logic                   frame_end,
    output logic                   do_en,
    output logic signed [O_BW-1:0] data_o,
    output logic        [6:0]      out_group_num,
    output logic        [9:0]      out_first_idx,
    output logic        [9:0]      out_bin_cnt,
    output logic                   err_order
);

    localparam int c_PW = I_BW + W_BW + 1;

    // Saturation bounds expressed at accumulator width.
    localparam logic signed [ACC_BW-1:0] c_OMAX =
        {{(ACC_BW-O_BW+1){1'b0}}, {(O_BW-1){1'b1}}};
    localparam logic signed [ACC_BW-1:0] c_OMIN =
        {{(ACC_BW-O_BW+1){1'b1}}, {(O_BW-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Stage P: product register
    // ------------------------------------------------------------------
    logic signed [W_BW:0]     w_wt;
    logic signed [c_PW-1:0]   w_prod;

    logic                     r_p_valid;
    logic signed [c_PW-1:0]   r_p;
    logic        [6:0]        r_p_num;
    logic        [9:0]        r_p_idx;
    logic                     r_p_end;

    // Zero-extend the weight so the signed multiply treats it as unsigned.
    assign w_wt   = {1'b0, weight_i};
    assign w_prod = data_i * w_wt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_p_valid <= 1'b0;
            r_p       <= '0;
            r_p_num   <= '0;
            r_p_idx   <= '0;
            r_p_end   <= 1'b0;
        end else begin
            r_p_valid <= di_en;
            if (di_en) begin
                r_p     <= w_prod;
                r_p_num <= in_group_num;
                r_p_idx <= in_group_idx;
                r_p_end <= frame_end;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage A: band accumulator FSM
    // ------------------------------------------------------------------
    state_t                   r_state, w_nstate;
    logic signed [ACC_BW-1:0] r_acc, w_acc_nxt;
    logic        [9:0]        r_cnt, w_cnt_nxt;
    logic        [6:0]        r_num, w_num_nxt;
    logic        [9:0]        r_first, w_first_nxt;
    // Single-sample band held back when a band change and frame_end coincide.
    logic signed [ACC_BW-1:0] r_pend, w_pend_nxt;
    logic        [6:0]        r_pend_num, w_pend_num_nxt;
    logic        [9:0]        r_pend_idx, w_pend_idx_nxt;

    logic signed [ACC_BW-1:0] w_p_ext;
    logic                     w_fire;
    logic signed [ACC_BW-1:0] w_osum;
    logic        [9:0]        w_ocnt;
    logic        [6:0]        w_onum;
    logic        [9:0]        w_oidx;
    logic                     w_err_set;

    assign w_p_ext = {{(ACC_BW-c_PW){r_p[c_PW-1]}}, r_p};

    always_comb begin
        w_nstate       = r_state;
        w_acc_nxt      = r_acc;
        w_cnt_nxt      = r_cnt;
        w_num_nxt      = r_num;
        w_first_nxt    = r_first;
        w_pend_nxt     = r_pend;
        w_pend_num_nxt = r_pend_num;
        w_pend_idx_nxt = r_pend_idx;
        w_fire         = 1'b0;
        w_osum         = r_acc;
        w_ocnt         = r_cnt;
        w_onum         = r_num;
        w_oidx         = r_first;
        w_err_set      = 1'b0;

        case (r_state)
            ST_ACCUM: begin
                if (r_p_valid) begin
                    if (r_p_num == r_num) begin
                        if (r_p_end) begin
                            w_fire   = 1'b1;
                            w_osum   = r_acc + w_p_ext;
                            w_ocnt   = r_cnt + 10'd1;
                            w_nstate = ST_IDLE;
                        end else begin
                            w_acc_nxt = r_acc + w_p_ext;
                            w_cnt_nxt = r_cnt + 10'd1;
                        end
                    end else begin
                        // Old band goes out on this edge (output defaults).
                        w_fire    = 1'b1;
                        w_err_set = (r_p_num < r_num);
                        if (r_p_end) begin
                            w_pend_nxt     = w_p_ext;
                            w_pend_num_nxt = r_p_num;
                            w_pend_idx_nxt = r_p_idx;
                            w_nstate       = ST_FLUSH;
                        end else begin
                            w_acc_nxt   = w_p_ext;
                            w_cnt_nxt   = 10'd1;
                            w_num_nxt   = r_p_num;
                            w_first_nxt = r_p_idx;
                        end
                    end
                end
            end

            ST_FLUSH: begin
                w_fire = 1'b1;
                w_osum = r_pend;
                w_ocnt = 10'd1;
                w_onum = r_pend_num;
                w_oidx = r_pend_idx;
                if (r_p_valid) begin
                    if (r_p_end) begin
                        w_pend_nxt     = w_p_ext;
                        w_pend_num_nxt = r_p_num;
                        w_pend_idx_nxt = r_p_idx;
                    end else begin
                        w_acc_nxt   = w_p_ext;
                        w_cnt_nxt   = 10'd1;
                        w_num_nxt   = r_p_num;
                        w_first_nxt = r_p_idx;
                        w_nstate    = ST_ACCUM;
                    end
                end else begin
                    w_nstate = ST_IDLE;
                end
            end

            default: begin // ST_IDLE
                if (r_p_valid) begin
                    if (r_p_end) begin
                        w_fire = 1'b1;
                        w_osum = w_p_ext;
                        w_ocnt = 10'd1;
                        w_onum = r_p_num;
                        w_oidx = r_p_idx;
                    end else begin
                        w_acc_nxt   = w_p_ext;
                        w_cnt_nxt   = 10'd1;
                        w_num_nxt   = r_p_num;
                        w_first_nxt = r_p_idx;
                        w_nstate    = ST_ACCUM;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_num      <= '0;
            r_first    <= '0;
            r_pend     <= '0;
            r_pend_num <= '0;
            r_pend_idx <= '0;
        end else begin
            r_state    <= w_nstate;
            r_acc      <= w_acc_nxt;
            r_cnt      <= w_cnt_nxt;
            r_num      <= w_num_nxt;
            r_first    <= w_first_nxt;
            r_pend     <= w_pend_nxt;
            r_pend_num <= w_pend_num_nxt;
            r_pend_idx <= w_pend_idx_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Output formatting: floor shift, then clamp to the O_BW range
    // ------------------------------------------------------------------
    logic signed [ACC_BW-1:0] w_shift;
    logic signed [ACC_BW-1:0] w_clamp;

    assign w_shift = w_osum >>> SHIFT;

    always_comb begin
        w_clamp = w_shift;
        if (w_shift > c_OMAX) begin
            w_clamp = c_OMAX;
        end else if (w_shift < c_OMIN) begin
            w_clamp = c_OMIN;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            do_en         <= 1'b0;
            data_o        <= '0;
            out_group_num <= '0;
            out_first_idx <= '0;
            out_bin_cnt   <= '0;
            err_order     <= 1'b0;
        end else begin
            do_en <= w_fire;
            if (w_fire) begin
                data_o        <= w_clamp[O_BW-1:0];
                out_group_num <= w_onum;
                out_first_idx <= w_oidx;
                out_bin_cnt   <= w_ocnt;
            end
            if (w_err_set) begin
                err_order <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mel_band_accum.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mel_band_accum
//  Purpose  : Directed self-checking bench for mel_band_accum. Drives a
//             linear sequence of sample vectors and compares each band
//             output with hand-computed values.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mel_band_accum;

    logic               clk;
    logic               rst;
    logic               di_en;
    logic signed [13:0] data_i;
    logic        [11:0] weight_i;
    logic        [9:0]  in_group_idx;
    logic        [6:0]  in_group_num;
    logic               frame_end;
    logic               do_en;
    logic signed [23:0] data_o;
    logic        [6:0]  out_group_num;
    logic        [9:0]  out_first_idx;
    logic        [9:0]  out_bin_cnt;
    logic               err_order;

    int n_cmp  = 0;
    int n_fail = 0;
    int fires;

    mel_band_accum #(
        .I_BW  (14),
        .W_BW  (12),
        .ACC_BW(40),
        .SHIFT (11),
        .O_BW  (24)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .di_en        (di_en),
        .data_i       (data_i),
        .weight_i     (weight_i),
        .in_group_idx (in_group_idx),
        .in_group_num (in_group_num),
        .frame_end    (frame_end),
        .do_en        (do_en),
        .data_o       (data_o),
        .out_group_num(out_group_num),
        .out_first_idx(out_first_idx),
        .out_bin_cnt  (out_bin_cnt),
        .err_order    (err_order)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // Present one sample, then advance past the next rising edge.
    task automatic send(input int d, input int w, input int idx,
                        input int num, input logic fe);
        di_en        = 1'b1;
        data_i       = 14'(d);
        weight_i     = 12'(w);
        in_group_idx = 10'(idx);
        in_group_num = 7'(num);
        frame_end    = fe;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        di_en     = 1'b0;
        frame_end = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_band(input string tag, input int d, input int cnt,
                            input int num, input int first);
        chk({tag, ".do_en"}, 64'(do_en), 64'd1);
        chk({tag, ".data"},  64'(data_o), 64'(d));
        chk({tag, ".cnt"},   64'(out_bin_cnt), 64'(cnt));
        chk({tag, ".num"},   64'(out_group_num), 64'(num));
        chk({tag, ".first"}, 64'(out_first_idx), 64'(first));
    endtask

    initial begin
        rst = 1'b1; di_en = 1'b0; data_i = '0; weight_i = '0;
        in_group_idx = '0; in_group_num = '0; frame_end = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.do_en", 64'(do_en), 64'd0);
        chk("reset.data",  64'(data_o), 64'd0);
        chk("reset.cnt",   64'(out_bin_cnt), 64'd0);
        chk("reset.err",   64'(err_order), 64'd0);
        rst = 1'b0;
        idle();

        // Band 5 (100+200+300) closed by band 6 carrying frame_end.
        send(100, 2048, 10, 5, 1'b0);
        send(200, 2048, 11, 5, 1'b0);
        send(300, 2048, 12, 5, 1'b0);
        send(50,  2048, 13, 6, 1'b1);
        chk("t1.no_early", 64'(do_en), 64'd0);
        idle();
        chk_band("t1.b5", 600, 3, 5, 10);
        idle();
        chk_band("t1.b6", 50, 1, 6, 13);
        idle();
        chk("t1.quiet", 64'(do_en), 64'd0);

        // Band 2 with bubbles in the middle.
        fires = 0;
        send(-1000, 1024, 20, 2, 1'b0);
        idle(); fires += int'(do_en);
        idle(); fires += int'(do_en);
        send(-1000, 1024, 23, 2, 1'b1); fires += int'(do_en);
        chk("t2.bubbles", 64'(fires), 64'd0);
        idle();
        chk_band("t2.b2", -1000, 2, 2, 20);
        chk("t2.held_data", 64'(data_o), 64'(-1000));
        idle();
        chk("t2.single", 64'(do_en), 64'd0);
        chk("t2.hold", 64'(data_o), 64'(-1000));

        // Positive saturation: 513 * 8191 * 4095 >> 11 exceeds 2^23-1.
        fires = 0;
        for (int i = 0; i < 513; i++) begin
            send(8191, 4095, i, 0, (i == 512));
            fires += int'(do_en);
        end
        chk("t3.no_early", 64'(fires), 64'd0);
        idle();
        chk_band("t3.sat", 8388607, 513, 0, 0);

        // Single-sample band from IDLE; -1 >>> 11 floors to -1.
        send(-1, 1, 30, 3, 1'b1);
        idle();
        chk_band("t3b.floor", -1, 1, 3, 30);
        chk("t3b.err", 64'(err_order), 64'd0);

        // Band order error: 7 then 4 with frame_end.
        send(10, 2048, 40, 7, 1'b0);
        send(20, 2048, 41, 4, 1'b1);
        idle();
        chk_band("t4.b7", 10, 1, 7, 40);
        chk("t4.err_set", 64'(err_order), 64'd1);
        idle();
        chk_band("t4.b4", 20, 1, 4, 41);
        idle();
        chk("t4.quiet", 64'(do_en), 64'd0);
        chk("t4.err_sticky", 64'(err_order), 64'd1);

        // Reset in the middle of band 9 discards it.
        send(5, 2048, 60, 9, 1'b0);
        send(5, 2048, 61, 9, 1'b0);
        send(5, 2048, 62, 9, 1'b0);
        idle();
        rst = 1'b1;
        #2;
        chk("t5.rst_do_en", 64'(do_en), 64'd0);
        chk("t5.rst_data",  64'(data_o), 64'd0);
        chk("t5.rst_num",   64'(out_group_num), 64'd0);
        chk("t5.rst_first", 64'(out_first_idx), 64'd0);
        chk("t5.rst_err",   64'(err_order), 64'd0);
        rst = 1'b0;
        fires = 0;
        idle(); fires += int'(do_en);
        idle(); fires += int'(do_en);
        chk("t5.no_out", 64'(fires), 64'd0);
        send(40, 2048, 70, 9, 1'b1);
        idle();
        chk_band("t5.b9", 40, 1, 9, 70);

        // Back-to-back frames: band 1 ends a frame, band 0 starts next cycle.
        send(30, 2048, 100, 1, 1'b0);
        send(70, 2048, 101, 1, 1'b1);
        send(8,  2048, 0,   0, 1'b0);
        chk_band("t6.b1", 100, 2, 1, 100);
        send(12, 2048, 1,   0, 1'b1);
        chk("t6.gap", 64'(do_en), 64'd0);
        idle();
        chk_band("t6.b0", 20, 2, 0, 0);
        chk("t6.err", 64'(err_order), 64'd0);
        idle();
        chk("t6.quiet", 64'(do_en), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mel_band_accum.md
Name: mel_band_accum

Overview:
- Sits directly downstream of the bin-select stage in the log-mel pipeline.
- Receives power-spectrum bins tagged with a bin index and a mel band number, each paired with a filter weight.
- Multiply-accumulates the weighted bins per mel band and emits one scaled, saturated energy value per band to the log stage.
- Fully pipelined with no backpressure: one sample may be accepted every cycle.

Parameters:
- I_BW, 14: input sample width (signed).
- W_BW, 12: filter weight width (unsigned; 1.0 = 2^SHIFT).
- ACC_BW, 40: accumulator width (signed). Must be >= I_BW+W_BW+11, so no overflow is possible.
- SHIFT, 11: arithmetic right shift applied to the band sum before saturation.
- O_BW, 24: output width (signed).

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- di_en  in  1  input sample valid.
- data_i  in  I_BW  signed bin value.
- weight_i  in  W_BW  unsigned filter weight for this bin/band pair.
- in_group_idx  in  10  FFT bin index, 0-512.
- in_group_num  in  7  mel band number, 0-88.
- frame_end  in  1  marks the last sample of a frame; qualified by di_en.
- do_en  out  1  one-cycle output valid pulse.
- data_o  out  O_BW  signed band energy.
- out_group_num  out  7  band number of data_o.
- out_first_idx  out  10  bin index of the first sample in the band.
- out_bin_cnt  out  10  number of samples accumulated into the band.
- err_order  out  1  sticky flag: band number decreased within a frame.

Behaviour:
- Reset (async, any time):
  - do_en=0, data_o=0, out_group_num=0, out_first_idx=0, out_bin_cnt=0, err_order=0.
  - Accumulator=0, product stage invalid, FSM in IDLE.
  - A band in progress is discarded with no output.
- Stage P (edge where di_en=1):
  - p = data_i * signed({0,weight_i}), I_BW+W_BW+1 bits.
  - Registered together with in_group_num, in_group_idx and frame_end.
  - When di_en=0 the stage is invalid (a bubble).
- Stage A acts on the edge after stage P. FSM states:
  - IDLE, no band open:
    - Valid p opens a band: acc=p, cnt=1, num/first_idx latched → ACCUM.
    - If p also has frame_end, output p immediately and stay IDLE.
  - ACCUM:
    - Valid p with the same num: acc+=p, cnt+=1.
    - Valid p with a different num: output the old band, acc=p, cnt=1, latch the new num/first_idx.
    - If the new num < old num, set err_order (sticky). The sample is still processed as a new band.
    - Valid p with frame_end and the same num: output (acc+p, cnt+1) → IDLE.
    - Valid p with frame_end and a different num: output the old band this edge, hold p as pending → FLUSH.
    - Bubbles never close a band.
  - FLUSH:
    - Output the pending single-sample band, then handle p exactly as IDLE would.
    - If p also carries frame_end, it becomes the new pending value and the FSM stays in FLUSH.
- Output formatting:
  - data_o = saturate_O_BW(sum >>> SHIFT), arithmetic shift (floor).
  - Clamp to [-2^(O_BW-1), 2^(O_BW-1)-1].
- Output timing:
  - do_en is high exactly one cycle per band; all out_* registered on the same edge.
  - out_* hold their value when do_en=0.
- Latency:
  - A band closed by frame_end is output 2 edges after that sample is accepted.
  - A band closed by a band change is output 2 edges after the first sample of the next band.
  - The pending band from the FLUSH path is output 3 edges after its sample.

Test Plan:
- Band 5, weight 2048 on every sample, data 100, 200, 300 (idx 10-12); then band 6 data 50 with frame_end → band 5 output: data_o=600, cnt=3, first_idx=10. Next cycle, band 6 output: data_o=50, cnt=1.
- Band 2 with bubbles: data -1000, idle, idle, -1000, weight 1024, frame_end on the last sample → a single output: data_o=-1000, cnt=2. No output during the bubbles.
- Saturation: 513 samples of data 8191, weight 4095, band 0, frame_end on the last sample → data_o=8388607, cnt=513.
- Order error: band 7 data 10 (w 2048), then band 4 data 20 with frame_end → outputs 10 then 20 on consecutive cycles; err_order=1 and stays set until reset.
- Reset mid-band: 3 samples into band 9, pulse rst → no do_en. A following band 9 sample 40 with frame_end gives data_o=40, cnt=1.
- Back-to-back frames: frame A ends (band 1 closed by frame_end); frame B's first sample arrives the next cycle → both bands are output correctly with no lost or merged samples.
